// File: rtl/me_branch_resolve_t.sv
`default_nettype none
// ============================================================================
// me_branch_resolve_t : memory-stage branch/jump resolution with redirect,
//                       wrong-path squash window and performance counters
// Revision: 1.0
// ============================================================================
module me_branch_resolve_t #(
    parameter int XLEN        = 32,
    parameter int FLUSH_DEPTH = 2,
    parameter int CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ACT,
    input  logic             STALL,
    input  logic [3:0]       r_me1_branchop_Q,
    input  logic [XLEN-1:0]  r_me1_src1_Q,
    input  logic [XLEN-1:0]  r_me1_src2_Q,
    input  logic [XLEN-1:0]  r_me1_pc_Q,
    input  logic [XLEN-1:0]  r_me1_imm_Q,
    input  logic             r_me1_pred_Q,
    input  logic             cnt_clr,
    output logic             s_me1_pcsrc_Q,
    output logic [XLEN-1:0]  s_me1_target_Q,
    output logic             s_me1_squash_Q,
    output logic             s_me1_busy_Q,
    output logic [CNT_W-1:0] branch_cnt_Q,
    output logic [CNT_W-1:0] mispred_cnt_Q
);

    localparam logic [3:0] c_op_bne  = 4'd2;
    localparam logic [3:0] c_op_beq  = 4'd3;
    localparam logic [3:0] c_op_blt  = 4'd4;
    localparam logic [3:0] c_op_bge  = 4'd5;
    localparam logic [3:0] c_op_bltu = 4'd6;
    localparam logic [3:0] c_op_bgeu = 4'd7;
    localparam logic [3:0] c_op_jal  = 4'd8;
    localparam logic [3:0] c_op_jalr = 4'd9;

    localparam logic [2:0]      c_flush_depth = 3'(FLUSH_DEPTH);
    localparam logic [XLEN-1:0] c_inst_bytes  = XLEN'(4);
    localparam logic [XLEN-1:0] c_lsb_mask    = ~XLEN'(1);
    localparam logic [CNT_W-1:0] c_cnt_one    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SHADOW   = 2'd2
    } state_t;

    state_t           r_state;
    logic [2:0]       r_shadow_cnt;
    logic             r_pcsrc;
    logic             r_squash;
    logic             r_busy;
    logic [XLEN-1:0]  r_target;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_eq;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_taken;
    logic             w_is_branch;
    logic             w_squash_now;
    logic             w_eval;
    logic             w_mis;
    logic [XLEN-1:0]  w_pc_rel;
    logic [XLEN-1:0]  w_jalr_sum;
    logic [XLEN-1:0]  w_seq_pc;
    logic [XLEN-1:0]  w_target;

    assign w_eq   = (r_me1_src1_Q == r_me1_src2_Q);
    assign w_lt_s = ($signed(r_me1_src1_Q) < $signed(r_me1_src2_Q));
    assign w_lt_u = (r_me1_src1_Q < r_me1_src2_Q);

    always_comb begin
        w_taken = 1'b0;
        case (r_me1_branchop_Q)
            c_op_bne:           w_taken = ~w_eq;
            c_op_beq:           w_taken = w_eq;
            c_op_blt:           w_taken = w_lt_s;
            c_op_bge:           w_taken = ~w_lt_s;
            c_op_bltu:          w_taken = w_lt_u;
            c_op_bgeu:          w_taken = ~w_lt_u;
            c_op_jal, c_op_jalr: w_taken = 1'b1;
            default:            w_taken = 1'b0;
        endcase
    end

    assign w_is_branch = (r_me1_branchop_Q >= c_op_bne) && (r_me1_branchop_Q <= c_op_jalr);

    // Adders wrap at XLEN; carries out are intentionally dropped.
    assign w_pc_rel   = r_me1_pc_Q + r_me1_imm_Q;
    assign w_jalr_sum = r_me1_src1_Q + r_me1_imm_Q;
    assign w_seq_pc   = r_me1_pc_Q + c_inst_bytes;

    always_comb begin
        w_target = w_seq_pc;
        if (r_me1_branchop_Q == c_op_jalr) begin
            w_target = w_jalr_sum & c_lsb_mask;
        end else if (w_taken) begin
            w_target = w_pc_rel;
        end
    end

    assign w_squash_now = (r_state != ST_IDLE);
    assign w_eval       = ACT & ~STALL & ~w_squash_now & w_is_branch;
    assign w_mis        = w_eval & (w_taken != r_me1_pred_Q);

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state      <= ST_IDLE;
            r_shadow_cnt <= 3'd0;
            r_pcsrc      <= 1'b0;
            r_squash     <= 1'b0;
            r_busy       <= 1'b0;
            r_target     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_mis) begin
                        r_state  <= ST_REDIRECT;
                        r_pcsrc  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_target <= w_target;
                    end
                end
                ST_REDIRECT: begin
                    // Single-cycle pulse regardless of STALL.
                    r_state      <= ST_SHADOW;
                    r_pcsrc      <= 1'b0;
                    r_squash     <= 1'b1;
                    r_shadow_cnt <= c_flush_depth;
                end
                ST_SHADOW: begin
                    if (!STALL) begin
                        if (r_shadow_cnt <= 3'd1) begin
                            r_state      <= ST_IDLE;
                            r_squash     <= 1'b0;
                            r_busy       <= 1'b0;
                            r_shadow_cnt <= 3'd0;
                        end else begin
                            r_shadow_cnt <= r_shadow_cnt - 3'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_pcsrc  <= 1'b0;
                    r_squash <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else if (cnt_clr) begin
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_eval && !(&r_branch_cnt)) begin
                r_branch_cnt <= r_branch_cnt + c_cnt_one;
            end
            if (w_mis && !(&r_mispred_cnt)) begin
                r_mispred_cnt <= r_mispred_cnt + c_cnt_one;
            end
        end
    end

    assign s_me1_pcsrc_Q  = r_pcsrc;
    assign s_me1_target_Q = r_target;
    assign s_me1_squash_Q = r_squash;
    assign s_me1_busy_Q   = r_busy;
    assign branch_cnt_Q   = r_branch_cnt;
    assign mispred_cnt_Q  = r_mispred_cnt;

endmodule
`default_nettype wire

// File: doc/me_branch_resolve_t.md
Name: me_branch_resolve_t

Overview:
- Memory-stage branch resolution unit; successor to the fixed 3-bit BEQ/BNE-only pcsrc decode.
- Resolves the full RV32/RV64 conditional branch set plus JAL/JALR on XLEN-wide operands, compares the result against the fetch-stage prediction, and issues a registered one-cycle redirect with target.
- Squashes the wrong-path shadow for FLUSH_DEPTH active cycles after each redirect.
- Keeps saturating branch and mispredict counters for performance monitoring.

Parameters:
- XLEN, 32: operand, PC and target width (32 or 64).
- FLUSH_DEPTH, 2: number of non-stalled cycles squashed after a redirect (1..7).
- CNT_W, 16: width of each performance counter.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-low
- ACT  in  1  stage holds a valid instruction
- STALL  in  1  pipeline stall; stage contents are held
- r_me1_branchop_Q  in  4  branch opcode
- r_me1_src1_Q  in  XLEN  rs1 value
- r_me1_src2_Q  in  XLEN  rs2 value
- r_me1_pc_Q  in  XLEN  instruction PC
- r_me1_imm_Q  in  XLEN  sign-extended offset
- r_me1_pred_Q  in  1  fetch predicted taken
- cnt_clr  in  1  clear both counters
- s_me1_pcsrc_Q  out  1  redirect pulse to fetch
- s_me1_target_Q  out  XLEN  redirect PC
- s_me1_squash_Q  out  1  current stage instruction is wrong-path
- s_me1_busy_Q  out  1  FSM not in IDLE
- branch_cnt_Q  out  CNT_W  resolved branch/jump count
- mispred_cnt_Q  out  CNT_W  mispredict count

Behaviour:
- Opcode encoding (legacy values kept):
  - 0, 1: none
  - 2: BNE; 3: BEQ
  - 4: BLT; 5: BGE (signed)
  - 6: BLTU; 7: BGEU (unsigned)
  - 8: JAL; 9: JALR
  - 10..15: none
- taken:
  - Per-op compare for 2..7.
  - Always 1 for 8 and 9.
  - 0 for all none opcodes.
- Target, modulo 2^XLEN with carries discarded:
  - taken and op != 9: pc + imm.
  - op 9: (src1 + imm) with bit 0 cleared.
  - not taken: pc + 4.
- Qualifier: eval = ACT & !STALL & !squash_now & (op in 2..9).
- Mispredict: mis = eval & (taken != r_me1_pred_Q).
- FSM states: IDLE, REDIRECT, SHADOW.
  - IDLE, mis = 1: load target register, go to REDIRECT.
  - REDIRECT: lasts exactly 1 cycle with s_me1_pcsrc_Q = 1. Go to SHADOW and load shadow counter with FLUSH_DEPTH.
  - SHADOW: s_me1_squash_Q = 1. Counter decrements on each cycle with STALL = 0 and holds while STALL = 1. Return to IDLE in the cycle after the counter reaches 0, i.e. after exactly FLUSH_DEPTH non-stalled cycles.
- squash_now is 1 in REDIRECT and SHADOW. Instructions seen then are not evaluated, not counted, and cannot redirect.
- Latency: redirect is visible the cycle after the evaluating edge. The target is stable while s_me1_pcsrc_Q = 1 and holds its value afterwards.
- STALL in IDLE: nothing evaluated. STALL arriving during REDIRECT does not extend the pulse.
- Counters:
  - branch_cnt increments on eval; mispred_cnt increments on mis.
  - Both saturate at all-ones; no wrap.
  - cnt_clr has priority over increment; clear takes effect next edge.
- Reset (RST = 0 at an edge), including mid-REDIRECT or mid-SHADOW:
  - FSM returns to IDLE.
  - Outputs next cycle: pcsrc 0, target 0, squash 0, busy 0, both counters 0.
  - Any pending redirect is discarded.
- s_me1_busy_Q = 1 whenever state != IDLE.

Test Plan:
- XLEN=32, BLT, src1=0xFFFFFFFF, src2=1, pred=0 -> taken (signed −1<1): pcsrc pulses 1 cycle later, target = pc+imm, mispred_cnt=1, branch_cnt=1.
- BLTU, same operands, pred=0 -> not taken, no redirect, branch_cnt=1, mispred_cnt=0. BEQ equal operands with pred=1 -> no redirect.
- JALR, src1=0x1003, imm=4, pred=0 -> target 0x1006. Next two cycles with ACT=1 and mispredicting ops set squash=1, cause no redirect and no count. FLUSH_DEPTH=2 with a 3-cycle STALL in SHADOW -> squash lasts 5 cycles.
- pc=0xFFFFFFFC, BNE not taken, pred=1 -> target = 0x00000000 (wrap).
- Force mispred_cnt to 0xFFFF (CNT_W=16) via 65535 mispredicts -> stays 0xFFFF. cnt_clr together with a mispredict -> 0.
- Assert RST=0 in the REDIRECT cycle -> next cycle all outputs 0 and state IDLE; a following mispredict redirects normally.
